// File: rtl/lock_key_sequencer.sv
// lock_key_sequencer: serial key loader with even-parity check for a key-locked FSM.
// Bits arrive LSB first, followed by one parity bit. A good key is released to
// the locked FSM together with its enable. Repeated parity failures lock the
// sequencer out until reset.
// Optional feature: define KEY_SCRUB_EN to hide key_out (force it to 0) outside RUN.
// All flops update on the falling clock edge. rst is asynchronous and active low.

module lock_key_sequencer #(
  parameter int KEY_W    = 8,
  parameter int MAX_FAIL = 3,
  parameter int FAIL_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              key_bit,
  input  logic              key_valid,
  output logic              key_ready,
  output logic [KEY_W-1:0]  key_out,
  output logic              fsm_en,
  output logic              key_ok,
  output logic              lockout,
  output logic [FAIL_W-1:0] fail_cnt
);

  // The counter must be able to hold KEY_W, which is the index of the parity bit.
  localparam int CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    RUN,
    LOCKOUT
  } state_t;

  state_t             state;
  logic [KEY_W-1:0]   staging;
  logic               parity_bit;
  logic [CNT_W-1:0]   bit_cnt;
  logic               parity_err;
  logic [FAIL_W-1:0]  fail_next;

  // Even parity over the staged key plus its parity bit, and the next failure count
  always_comb begin
    parity_err = ^{staging, parity_bit};
    fail_next  = fail_cnt + FAIL_W'(1);
  end

  // Sequencer FSM. Output flags are registered and always track the state they belong to.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      staging    <= '0;
      parity_bit <= 1'b0;
      bit_cnt    <= '0;
      key_out    <= '0;
      fail_cnt   <= '0;
      key_ready  <= 1'b0;
      fsm_en     <= 1'b0;
      key_ok     <= 1'b0;
      lockout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_req) begin
            state      <= LOAD;
            bit_cnt    <= '0;
            staging    <= '0;
            parity_bit <= 1'b0;
            key_ready  <= 1'b1;
          end
        end

        LOAD: begin
          if (key_valid) begin
            if (bit_cnt == CNT_W'(KEY_W)) begin
              parity_bit <= key_bit;
              key_ready  <= 1'b0;
              state      <= CHECK;
            end else begin
              for (int i = 0; i < KEY_W; i++) begin
                if (bit_cnt == CNT_W'(i)) begin
                  staging[i] <= key_bit;
                end
              end
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        CHECK: begin
          if (!parity_err) begin
            key_out  <= staging;
            fail_cnt <= '0;
            fsm_en   <= 1'b1;
            key_ok   <= 1'b1;
            state    <= RUN;
          end else begin
            fail_cnt <= fail_next;
            if (fail_next == FAIL_W'(MAX_FAIL)) begin
              lockout <= 1'b1;
              state   <= LOCKOUT;
            end else begin
              state <= IDLE;
            end
          end
        end

        RUN: begin
          if (load_req) begin
            state      <= LOAD;
            bit_cnt    <= '0;
            staging    <= '0;
            parity_bit <= 1'b0;
            key_ready  <= 1'b1;
            fsm_en     <= 1'b0;
            key_ok     <= 1'b0;
`ifdef KEY_SCRUB_EN
            key_out    <= '0;
`else
            key_out    <= key_out;
`endif
          end
        end

        LOCKOUT: begin
          lockout   <= 1'b1;
          key_ready <= 1'b0;
          fsm_en    <= 1'b0;
          key_ok    <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          key_ready <= 1'b0;
          fsm_en    <= 1'b0;
          key_ok    <= 1'b0;
          lockout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_key_sequencer.sv
// Self-checking bench for lock_key_sequencer (KEY_W=8, MAX_FAIL=3, FAIL_W=2).
// Load attempts come from a vector table. Each attempt pushes its expected
// result onto a scoreboard queue, and the entry is popped when the CHECK cycle
// completes. Hand-written sequences cover reset, reload with gaps, and lockout.

module tb_lock_key_sequencer;

  localparam int KEY_W    = 8;
  localparam int MAX_FAIL = 3;
  localparam int FAIL_W   = 2;

`ifdef KEY_SCRUB_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              load_req;
  logic              key_bit;
  logic              key_valid;
  logic              key_ready;
  logic [KEY_W-1:0]  key_out;
  logic              fsm_en;
  logic              key_ok;
  logic              lockout;
  logic [FAIL_W-1:0] fail_cnt;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic [7:0] key;
    logic       par;
    logic [8:0] gaps;
    logic       exp_en;
    logic [7:0] exp_key;
    logic [1:0] exp_fail;
    logic       exp_lock;
  } vec_t;

  vec_t vecs[9];
  vec_t sb[$];

  lock_key_sequencer #(
    .KEY_W   (KEY_W),
    .MAX_FAIL(MAX_FAIL),
    .FAIL_W  (FAIL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load_req (load_req),
    .key_bit  (key_bit),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_out  (key_out),
    .fsm_en   (fsm_en),
    .key_ok   (key_ok),
    .lockout  (lockout),
    .fail_cnt (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      check_count++;
      $display("[TB] FAIL %s_sb_empty: got empty queue, want one entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_fsm_en"},   32'(fsm_en),   32'(e.exp_en));
      check({tag, "_key_ok"},   32'(key_ok),   32'(e.exp_en));
      check({tag, "_key_out"},  32'(key_out),  32'(e.exp_key));
      check({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(e.exp_fail));
      check({tag, "_lockout"},  32'(lockout),  32'(e.exp_lock));
    end
  endtask

  // Issue load_req, stream key bits (inserting a gap before bit i when gaps[i] is set)
  // followed by the parity bit, then run the CHECK cycle.
  task automatic applyStimulus(input vec_t v, input string tag);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check({tag, "_ready_rise"}, 32'(key_ready), 32'd1);
    sb.push_back(v);
    for (int i = 0; i <= KEY_W; i++) begin
      if (v.gaps[i]) begin
        key_valid = 1'b0;
        key_bit   = 1'b1;
        tick();
      end
      key_valid = 1'b1;
      key_bit   = (i == KEY_W) ? v.par : v.key[i];
      tick();
    end
    key_valid = 1'b0;
    key_bit   = 1'b0;
    check({tag, "_check_ready"}, 32'(key_ready), 32'd0);
    check({tag, "_check_en"},    32'(fsm_en),    32'd0);
    tick();
    checkOutput(tag);
  endtask

  task automatic doReset();
    #2 rst = 1'b0;
    #1;
    @(posedge clk);
    rst = 1'b1;
    tick();
  endtask

  function automatic vec_t mk(input logic [7:0] key, input logic par, input logic [8:0] gaps,
                              input logic en, input logic [7:0] ekey, input logic [1:0] efail,
                              input logic elock);
    vec_t v;
    v.key = key; v.par = par; v.gaps = gaps; v.exp_en = en;
    v.exp_key = ekey; v.exp_fail = efail; v.exp_lock = elock;
    return v;
  endfunction

  initial begin
    logic [7:0] k3c;
    logic [7:0] kabort;

    rst       = 1'b0;
    load_req  = 1'b0;
    key_bit   = 1'b0;
    key_valid = 1'b0;

    vecs[0] = mk(8'hA5, 1'b0, 9'h000, 1'b1, 8'hA5, 2'd0, 1'b0);
    vecs[1] = mk(8'h3C, 1'b0, 9'h124, 1'b1, 8'h3C, 2'd0, 1'b0);
    vecs[2] = mk(8'hA5, 1'b1, 9'h000, 1'b0, SCRUB ? 8'h00 : 8'h3C, 2'd1, 1'b0);
    vecs[3] = mk(8'h0F, 1'b0, 9'h001, 1'b1, 8'h0F, 2'd0, 1'b0);
    vecs[4] = mk(8'h00, 1'b0, 9'h000, 1'b1, 8'h00, 2'd0, 1'b0);
    vecs[5] = mk(8'hFF, 1'b0, 9'h100, 1'b1, 8'hFF, 2'd0, 1'b0);
    vecs[6] = mk(8'h01, 1'b1, 9'h000, 1'b1, 8'h01, 2'd0, 1'b0);
    vecs[7] = mk(8'h01, 1'b0, 9'h000, 1'b0, SCRUB ? 8'h00 : 8'h01, 2'd1, 1'b0);
    vecs[8] = mk(8'h80, 1'b1, 9'h0AA, 1'b1, 8'h80, 2'd0, 1'b0);

    // Reset values while rst is held low
    repeat (2) tick();
    check("rst_ready",   32'(key_ready), 32'd0);
    check("rst_en",      32'(fsm_en),    32'd0);
    check("rst_key_ok",  32'(key_ok),    32'd0);
    check("rst_lockout", 32'(lockout),   32'd0);
    check("rst_key_out", 32'(key_out),   32'd0);
    check("rst_fail",    32'(fail_cnt),  32'd0);
    @(posedge clk);
    rst = 1'b1;
    tick();

    // key_valid in IDLE is ignored
    key_valid = 1'b1;
    key_bit   = 1'b1;
    repeat (3) tick();
    check("idle_ignore_ready", 32'(key_ready), 32'd0);
    check("idle_ignore_en",    32'(fsm_en),    32'd0);
    key_valid = 1'b0;
    key_bit   = 1'b0;

    // Bad parity straight after reset: key_out stays 0
    applyStimulus(mk(8'hA5, 1'b1, 9'h000, 1'b0, 8'h00, 2'd1, 1'b0), "bad_after_rst");

    // Table of load attempts; each one starts from IDLE or RUN
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Async reset while in RUN: outputs clear without waiting for a clock edge
    #2 rst = 1'b0;
    #1;
    check("async_en",      32'(fsm_en),    32'd0);
    check("async_key_ok",  32'(key_ok),    32'd0);
    check("async_key_out", 32'(key_out),   32'd0);
    check("async_ready",   32'(key_ready), 32'd0);
    check("async_fail",    32'(fail_cnt),  32'd0);
    @(posedge clk);
    rst = 1'b1;
    tick();

    // Reload: load 0xA5, then reload 0x3C with key_valid gaps
    applyStimulus(mk(8'hA5, 1'b0, 9'h000, 1'b1, 8'hA5, 2'd0, 1'b0), "reload_base");
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("reload_en_drop",    32'(fsm_en),    32'd0);
    check("reload_key_ok",     32'(key_ok),    32'd0);
    check("reload_ready",      32'(key_ready), 32'd1);
    check("reload_key_during", 32'(key_out),   SCRUB ? 32'h00 : 32'hA5);
    k3c = 8'h3C;
    for (int i = 0; i <= KEY_W; i++) begin
      if (i == 2 || i == 5) begin
        key_valid = 1'b0;
        key_bit   = 1'b1;
        tick();
        check($sformatf("reload_gap%0d_ready", i), 32'(key_ready), 32'd1);
      end
      key_valid = 1'b1;
      key_bit   = (i == KEY_W) ? 1'b0 : k3c[i];
      tick();
      if (i < KEY_W) check($sformatf("reload_bit%0d_ready", i), 32'(key_ready), 32'd1);
      if (i == 4) check("reload_key_mid", 32'(key_out), SCRUB ? 32'h00 : 32'hA5);
    end
    key_valid = 1'b0;
    check("reload_check_ready", 32'(key_ready), 32'd0);
    check("reload_check_en",    32'(fsm_en),    32'd0);
    tick();
    check("reload_final_en",  32'(fsm_en),  32'd1);
    check("reload_final_key", 32'(key_out), 32'h3C);

    // Reset after 4 bits of a load, then a full clean load of 0x0F
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    kabort = 8'h0A;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1;
      key_bit   = kabort[i];
      tick();
    end
    key_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midload_rst_ready", 32'(key_ready), 32'd0);
    check("midload_rst_key",   32'(key_out),   32'd0);
    @(posedge clk);
    rst = 1'b1;
    tick();
    applyStimulus(mk(8'h0F, 1'b0, 9'h000, 1'b1, 8'h0F, 2'd0, 1'b0), "after_abort");

    // Lockout after three consecutive parity failures
    doReset();
    applyStimulus(mk(8'hA5, 1'b1, 9'h000, 1'b0, 8'h00, 2'd1, 1'b0), "lock1");
    applyStimulus(mk(8'h3C, 1'b1, 9'h000, 1'b0, 8'h00, 2'd2, 1'b0), "lock2");
    applyStimulus(mk(8'h00, 1'b1, 9'h000, 1'b0, 8'h00, 2'd3, 1'b1), "lock3");
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("locked_ready", 32'(key_ready), 32'd0);
    for (int i = 0; i <= KEY_W; i++) begin
      key_valid = 1'b1;
      key_bit   = (i == KEY_W) ? 1'b0 : k3c[i];
      tick();
    end
    key_valid = 1'b0;
    repeat (2) tick();
    check("locked_en",      32'(fsm_en),    32'd0);
    check("locked_ready2",  32'(key_ready), 32'd0);
    check("locked_flag",    32'(lockout),   32'd1);
    check("locked_fail",    32'(fail_cnt),  32'd3);
    check("locked_key_out", 32'(key_out),   32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
